// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte/half/word accesses over a req/ack data bus, MEM/WB register.
// Defining MEM_TIMEOUT_EN adds an ACCESS-cycle counter that aborts a bus access after TIMEOUT cycles.

module mem_stage_lsu #(
  parameter int AW      = 32,
  parameter int RAW     = 5,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           in_valid,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     size,
  input  logic           sign_ext,
  input  logic [AW-1:0]  addr,
  input  logic [31:0]    wdata,
  input  logic [RAW-1:0] write_reg,
  input  logic           reg_write,
  input  logic [1:0]     mem_to_reg,
  input  logic [31:0]    pc_plus4,
  input  logic           lu_op,
  input  logic [31:0]    lu_data,
  output logic           stall,
  output logic           bus_req,
  output logic           bus_we,
  output logic [AW-1:0]  bus_addr,
  output logic [3:0]     bus_be,
  output logic [31:0]    bus_wdata,
  input  logic [31:0]    bus_rdata,
  input  logic           bus_ack,
  output logic           wb_valid,
  output logic [31:0]    wb_data,
  output logic [RAW-1:0] wb_reg,
  output logic           wb_reg_write,
  output logic           misalign,
  output logic [AW-1:0]  bad_addr,
  output logic           bus_err
);

  typedef enum logic [0:0] {IDLE, ACCESS} state_e;

  state_e state_q, state_d;

  logic           memop, misaligned, aligned_op, misaligned_op;
  logic           ack_hit, timeout_hit, done;
  logic [3:0]     be_w;
  logic [31:0]    wdata_w, alt_w, load_w;
  logic           use_load_w;

  logic [AW-1:0]  addr_q;
  logic [3:0]     be_q;
  logic [31:0]    wdata_q, alt_q;
  logic           we_q, sign_q, use_load_q, regwr_q;
  logic [1:0]     lo_q, size_q;
  logic [RAW-1:0] reg_q;

  logic           wb_valid_q, wb_reg_write_q, misalign_q;
  logic [31:0]    wb_data_q;
  logic [RAW-1:0] wb_reg_q;
  logic [AW-1:0]  bad_addr_q;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_stage_lsu: TIMEOUT must lie in 1..65535");
  end

  assign memop         = in_valid & (mem_read | mem_write);
  assign misaligned    = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
  assign aligned_op    = memop & ~misaligned;
  assign misaligned_op = memop & misaligned;
  assign ack_hit       = (state_q == ACCESS) & bus_ack;
  assign done          = ack_hit | timeout_hit;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aligned_op) state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational on EX/MEM, so it is also gated by reset to keep all outputs low.
  always_comb begin
    stall   = 1'b0;
    bus_req = 1'b0;
    bus_we  = 1'b0;
    case (state_q)
      IDLE:    stall = aligned_op;
      ACCESS: begin
        bus_req = 1'b1;
        bus_we  = we_q;
        stall   = ~done;
      end
      default: ;
    endcase
    if (!reset_b) stall = 1'b0;
  end

  always_comb begin
    be_w    = 4'b1111;
    wdata_w = wdata;
    case (size)
      2'b00: begin
        be_w    = 4'b0001 << addr[1:0];
        wdata_w = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_w    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign use_load_w = ~lu_op & (mem_to_reg == 2'b01);
  assign alt_w      = lu_op ? lu_data : (mem_to_reg == 2'b00) ? 32'(addr) : pc_plus4;

  always_comb begin
    load_w = bus_rdata;
    case (size_q)
      2'b00: begin
        load_w[7:0]  = bus_rdata[{lo_q, 3'b000} +: 8];
        load_w[31:8] = {24{sign_q & load_w[7]}};
      end
      2'b01: begin
        load_w[15:0]  = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_w[31:16] = {16{sign_q & load_w[15]}};
      end
      default: ;
    endcase
  end

  // Everything the access and its writeback need is captured once, on entry to ACCESS.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lo_q       <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      alt_q      <= '0;
      use_load_q <= 1'b0;
      reg_q      <= '0;
      regwr_q    <= 1'b0;
    end else if (state_q == IDLE && aligned_op) begin
      addr_q     <= {addr[AW-1:2], 2'b00};
      be_q       <= be_w;
      wdata_q    <= wdata_w;
      we_q       <= mem_write;
      lo_q       <= addr[1:0];
      size_q     <= size;
      sign_q     <= sign_ext;
      alt_q      <= alt_w;
      use_load_q <= use_load_w;
      reg_q      <= write_reg;
      regwr_q    <= reg_write;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_reg_q       <= '0;
      misalign_q     <= 1'b0;
      bad_addr_q     <= '0;
    end else begin
      misalign_q <= (state_q == IDLE) & misaligned_op;
      if (state_q == IDLE) begin
        if (aligned_op) begin
          wb_valid_q     <= 1'b0;
          wb_reg_write_q <= 1'b0;
        end else begin
          wb_valid_q     <= in_valid;
          wb_reg_write_q <= reg_write & in_valid & ~misaligned_op;
          wb_reg_q       <= write_reg;
          wb_data_q      <= use_load_w ? 32'd0 : alt_w;
          if (misaligned_op) bad_addr_q <= addr;
        end
      end else if (ack_hit) begin
        wb_valid_q     <= 1'b1;
        wb_reg_write_q <= regwr_q;
        wb_reg_q       <= reg_q;
        wb_data_q      <= use_load_q ? load_w : alt_q;
      end else if (timeout_hit) begin
        wb_valid_q     <= 1'b1;
        wb_reg_write_q <= 1'b0;
        wb_reg_q       <= reg_q;
        wb_data_q      <= use_load_q ? 32'd0 : alt_q;
      end else begin
        wb_valid_q     <= 1'b0;
        wb_reg_write_q <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        bus_err_q;

  assign timeout_hit = (state_q == ACCESS) & ~bus_ack & (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (state_q != ACCESS) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_reg       = wb_reg_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misalign     = misalign_q;
  assign bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed bench for mem_stage_lsu against an arithmetic reference model.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.

module tb_mem_stage_lsu;

  logic        clk, reset_b;
  logic        in_valid, mem_read, mem_write, sign_ext, reg_write, lu_op;
  logic [1:0]  size, mem_to_reg;
  logic [31:0] addr, wdata, pc_plus4, lu_data, bus_rdata;
  logic [4:0]  write_reg;
  logic        bus_ack;
  logic        stall, bus_req, bus_we, wb_valid, wb_reg_write, misalign, bus_err;
  logic [31:0] bus_addr, bus_wdata, wb_data, bad_addr;
  logic [3:0]  bus_be;
  logic [4:0]  wb_reg;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.AW(32), .RAW(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .write_reg(write_reg), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_plus4(pc_plus4), .lu_op(lu_op), .lu_data(lu_data), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_reg_write(wb_reg_write), .misalign(misalign),
    .bad_addr(bad_addr), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accesses described as byte counts and shifts.
  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int nb);
    return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sx);
    int nb = nbytes_of(sz);
    logic [31:0] m = lane_mask(nb);
    logic [31:0] v = (rd >> (8 * off)) & m;
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] off, input logic [1:0] sz);
    int bm = ((1 << nbytes_of(sz)) - 1) << off;
    return bm[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    int nb = nbytes_of(sz);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i += nb) r = r | ((wd & lane_mask(nb)) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_wb(input logic lu, input logic [31:0] lud,
                                           input logic [1:0] m2r, input logic [31:0] a,
                                           input logic [31:0] pc4, input logic [31:0] ld);
    if (lu) return lud;
    if (m2r == 2'd0) return a;
    if (m2r == 2'd1) return ld;
    return pc4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] r, input logic rw, input logic [1:0] m2r,
                          input logic [31:0] pc4, input logic lu, input logic [31:0] lud);
    in_valid = v; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a;
    wdata = wd; write_reg = r; reg_write = rw; mem_to_reg = m2r; pc_plus4 = pc4;
    lu_op = lu; lu_data = lud;
  endtask

  task automatic drive_bubble();
    drive_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Acts as the memory: acks after 'waits' un-acked ACCESS cycles, records what the bus showed.
  task automatic run_access(input int waits, input logic [31:0] rd, output int stalls,
                            output int reqs, output logic [3:0] be_s, output logic [31:0] wd_s,
                            output logic [31:0] a_s, output logic we_s);
    stalls = 0;
    reqs   = 0;
    if (stall) stalls++;
    if (bus_req) reqs++;
    tick();
    be_s = bus_be; wd_s = bus_wdata; a_s = bus_addr; we_s = bus_we;
    for (int i = 0; i < waits; i++) begin
      if (stall) stalls++;
      if (bus_req) reqs++;
      tick();
    end
    bus_ack = 1'b1;
    bus_rdata = rd;
    #1;
    if (stall) stalls++;
    if (bus_req) reqs++;
    tick();
    bus_ack = 1'b0;
    bus_rdata = $urandom;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5'd3, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req got %b want 0", bus_req); end
    checks++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin errors++; $display("[TB] FAIL reset_bus got %h want 0", {bus_we, bus_be, bus_addr, bus_wdata}); end
    checks++; if ({wb_valid, wb_data, wb_reg, wb_reg_write} !== '0) begin errors++; $display("[TB] FAIL reset_wb got %h want 0", {wb_valid, wb_data, wb_reg, wb_reg_write}); end
    checks++; if ({misalign, bad_addr, bus_err} !== '0) begin errors++; $display("[TB] FAIL reset_exc got %h want 0", {misalign, bad_addr, bus_err}); end
    drive_bubble();
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    int st, rq; logic [3:0] be; logic [31:0] wd, ba; logic we;
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd5, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    run_access(3, 32'hDEADBEEF, st, rq, be, wd, ba, we);
    checks++; if (st !== 4) begin errors++; $display("[TB] FAIL lw_stall_cycles got %0d want 4", st); end
    checks++; if (rq !== 4) begin errors++; $display("[TB] FAIL lw_req_cycles got %0d want 4", rq); end
    checks++; if (be !== 4'b1111 || ba !== 32'h10 || we !== 1'b0) begin errors++; $display("[TB] FAIL lw_bus got be=%b addr=%h we=%b want 1111 10 0", be, ba, we); end
    checks++; if (wb_data !== 32'hDEADBEEF || wb_reg !== 5'd5 || wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin
      errors++; $display("[TB] FAIL lw_wb got data=%h reg=%0d v=%b rw=%b want deadbeef 5 1 1", wb_data, wb_reg, wb_valid, wb_reg_write); end
    drive_bubble();
    tick();
  endtask

  task automatic test_sub_word_loads();
    int st, rq; logic [3:0] be; logic [31:0] wd, ba; logic we;
    logic [31:0] exp_d [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    logic [3:0]  exp_b [3] = '{4'b1000, 4'b1000, 4'b1100};
    for (int k = 0; k < 3; k++) begin
      drive_op(1'b1, 1'b1, 1'b0, (k == 2) ? 2'd1 : 2'd0, (k != 1), (k == 2) ? 32'h12 : 32'h13,
               32'd0, 5'd9, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
      #1;
      run_access(k, 32'h80FF_0000, st, rq, be, wd, ba, we);
      checks++; if (wb_data !== exp_d[k] || be !== exp_b[k] || ba !== 32'h10) begin
        errors++; $display("[TB] FAIL subword_load%0d got data=%h be=%b addr=%h want %h %b 10", k, wb_data, be, ba, exp_d[k], exp_b[k]); end
    end
    drive_bubble();
    tick();
  endtask

  task automatic test_store_half();
    int st, rq; logic [3:0] be; logic [31:0] wd, ba; logic we;
    drive_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 5'd0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
    #1;
    run_access(1, 32'd0, st, rq, be, wd, ba, we);
    checks++; if (ba !== 32'h20 || be !== 4'b1100 || wd !== 32'hABCDABCD || we !== 1'b1) begin
      errors++; $display("[TB] FAIL sh_bus got addr=%h be=%b wd=%h we=%b want 20 1100 abcdabcd 1", ba, be, wd, we); end
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL sh_wb got v=%b rw=%b want 1 0", wb_valid, wb_reg_write); end
    drive_bubble();
    tick();
  endtask

  task automatic test_misalign();
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h21, 32'd0, 5'd4, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_stall got stall=%b req=%b want 0 0", stall, bus_req); end
    tick();
    checks++; if (misalign !== 1'b1 || bad_addr !== 32'h21 || bus_req !== 1'b0) begin
      errors++; $display("[TB] FAIL mis_pulse got mis=%b bad=%h req=%b want 1 21 0", misalign, bad_addr, bus_req); end
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL mis_wb got v=%b rw=%b want 1 0", wb_valid, wb_reg_write); end
    drive_bubble();
    tick();
    checks++; if (misalign !== 1'b0 || bad_addr !== 32'h21) begin errors++; $display("[TB] FAIL mis_once got mis=%b bad=%h want 0 21", misalign, bad_addr); end
  endtask

  task automatic test_alu_lui_jal();
    drive_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h77, 32'd0, 5'd7, 1'b1, 2'd0, 32'd0, 1'b1, 32'h00050000);
    bus_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lui_stall got %b want 0", stall); end
    tick();
    checks++; if (wb_data !== 32'h00050000 || wb_reg_write !== 1'b1 || wb_reg !== 5'd7) begin
      errors++; $display("[TB] FAIL lui_wb got data=%h rw=%b reg=%0d want 00050000 1 7", wb_data, wb_reg_write, wb_reg); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack got req=%b want 0", bus_req); end
    bus_ack = 1'b0;
    drive_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h77, 32'd0, 5'd31, 1'b1, 2'd2, 32'h00400104, 1'b0, 32'd0);
    tick();
    checks++; if (wb_data !== 32'h00400104 || wb_reg !== 5'd31) begin errors++; $display("[TB] FAIL jal_wb got data=%h reg=%0d want 00400104 31", wb_data, wb_reg); end
    drive_bubble();
    tick();
    checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL bubble_wb got v=%b rw=%b want 0 0", wb_valid, wb_reg_write); end
  endtask

  task automatic test_back_to_back();
    int st, rq; logic [3:0] be; logic [31:0] wd, ba; logic we;
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 5'd1, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    run_access(0, 32'h11111111, st, rq, be, wd, ba, we);
    checks++; if (st !== 1 || wb_data !== 32'h11111111) begin errors++; $display("[TB] FAIL b2b_first got stall=%0d data=%h want 1 11111111", st, wb_data); end
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 5'd2, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    run_access(0, 32'h22222222, st, rq, be, wd, ba, we);
    checks++; if (st !== 1 || rq !== 1 || ba !== 32'h104 || wb_data !== 32'h22222222 || wb_reg !== 5'd2) begin
      errors++; $display("[TB] FAIL b2b_second got stall=%0d req=%0d addr=%h data=%h reg=%0d", st, rq, ba, wb_data, wb_reg); end
    drive_bubble();
    tick();
  endtask

  task automatic test_random();
    int st, rq, waits, kind, nb; logic [3:0] be; logic [31:0] wd, ba, a, rdv, expd; logic we;
    logic v, rd, wr, sx, rw, lu; logic [1:0] sz, m2r; logic [31:0] wdat, pc4, lud; logic [4:0] r;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      sz = 2'($urandom_range(0, 3)); sx = 1'($urandom); rw = 1'($urandom); r = 5'($urandom);
      wdat = $urandom; pc4 = $urandom; lud = $urandom; lu = ($urandom_range(0, 7) == 0);
      a = $urandom; m2r = 2'($urandom_range(0, 3)); rdv = $urandom;
      if (kind == 0) begin
        v = 1'($urandom);
        if (m2r == 2'd1) m2r = 2'd0;
        drive_op(v, 1'b0, 1'b0, sz, sx, a, wdat, r, rw, m2r, pc4, lu, lud);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_alu_stall got %b want 0", n, stall); end
        tick();
        expd = model_wb(lu, lud, m2r, a, pc4, 32'd0);
        checks++; if (wb_valid !== v || wb_reg_write !== (rw & v) || wb_data !== expd || wb_reg !== r) begin
          errors++; $display("[TB] FAIL rnd%0d_alu_wb got v=%b rw=%b d=%h want %b %b %h", n, wb_valid, wb_reg_write, wb_data, v, rw & v, expd); end
      end else if (kind == 3) begin
        if (sz == 2'd0) sz = 2'd2;
        nb = nbytes_of(sz);
        a = (a & ~32'h3) | ((nb == 2) ? (32'h1 | (a & 32'h2)) : 32'($urandom_range(1, 3)));
        wr = 1'($urandom);
        drive_op(1'b1, ~wr, wr, sz, sx, a, wdat, r, rw, m2r, pc4, lu, lud);
        #1;
        checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_mis_stall got %b %b want 0 0", n, stall, bus_req); end
        tick();
        checks++; if (misalign !== 1'b1 || bad_addr !== a || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
          errors++; $display("[TB] FAIL rnd%0d_mis got mis=%b bad=%h v=%b rw=%b want 1 %h 1 0", n, misalign, bad_addr, wb_valid, wb_reg_write, a); end
      end else begin
        nb = nbytes_of(sz);
        a = a & ~(32'(nb) - 32'd1);
        wr = (kind == 2);
        rd = wr ? 1'($urandom) : 1'b1;
        waits = $urandom_range(0, 3);
        drive_op(1'b1, rd, wr, sz, sx, a, wdat, r, rw, m2r, pc4, lu, lud);
        #1;
        run_access(waits, rdv, st, rq, be, wd, ba, we);
        expd = model_wb(lu, lud, m2r, a, pc4, model_load(rdv, a[1:0], sz, sx));
        checks++; if (st !== waits + 1 || rq !== waits + 1) begin errors++; $display("[TB] FAIL rnd%0d_latency got stall=%0d req=%0d want %0d", n, st, rq, waits + 1); end
        checks++; if (be !== model_be(a[1:0], sz) || ba !== (a & ~32'h3) || we !== wr) begin
          errors++; $display("[TB] FAIL rnd%0d_bus got be=%b addr=%h we=%b want %b %h %b", n, be, ba, we, model_be(a[1:0], sz), a & ~32'h3, wr); end
        checks++; if (wd !== model_wdata(wdat, sz)) begin errors++; $display("[TB] FAIL rnd%0d_wdata got %h want %h", n, wd, model_wdata(wdat, sz)); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== rw || wb_reg !== r || wb_data !== expd) begin
          errors++; $display("[TB] FAIL rnd%0d_wb got v=%b rw=%b reg=%0d d=%h want 1 %b %0d %h", n, wb_valid, wb_reg_write, wb_reg, wb_data, rw, r, expd); end
      end
    end
    drive_bubble();
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 5'd6, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_before got %b want 1", bus_req); end
    reset_b = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_req got req=%b stall=%b want 0 0", bus_req, stall); end
    checks++; if ({bus_be, bus_addr, wb_valid, wb_data, misalign, bad_addr} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_outs got %h want 0", {bus_be, bus_addr, wb_valid, wb_data, misalign, bad_addr}); end
    tick();
    drive_bubble();
    reset_b = 1'b1;
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_abandoned got req=%b want 0", bus_req); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqs = 0;
    logic last_stall = 1'b1;
    drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 5'd8, 1'b1, 2'd1, 32'd0, 1'b0, 32'd0);
    #1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus_req) break;
      reqs++;
      last_stall = stall;
    end
    drive_bubble();
    checks++; if (reqs !== 4) begin errors++; $display("[TB] FAIL timeout_cycles got %0d want 4", reqs); end
    checks++; if (last_stall !== 1'b0) begin errors++; $display("[TB] FAIL timeout_release got stall=%b want 0", last_stall); end
    checks++; if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_pulse got err=%b v=%b rw=%b want 1 1 0", bus_err, wb_valid, wb_reg_write); end
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_once got %b want 0", bus_err); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_store_half();
    test_misalign();
    test_alu_lui_jal();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
